// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad event controller.
// Event records are {type, key}; state encoding for the key FSM.
package keypad_pkg;

  localparam int EVT_W = 6;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;
  localparam logic [1:0] EVT_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_REPEAT,
    S_SWITCH
  } kp_state_t;

  typedef struct packed {
    logic [1:0] typ;
    logic [3:0] key;
  } kp_evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous event FIFO with async reset.
// Head data reads as zero when empty; drop flags a rejected push.
module evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Turns debounced keypad scanner samples into PRESS/REPEAT/RELEASE
// events, queued for the playback FSM through a valid/ready FIFO.
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 256,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 2000,
  parameter int REPEAT_RATE    = 500,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    key_val,
  input  logic                          key_down,
  input  logic                          repeat_en,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [1:0]                    evt_type,
  output logic [3:0]                    evt_key,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [4:0]       cur;
  logic [4:0]       sample;
  logic [DW-1:0]    db_cnt;
  logic [DW-1:0]    db_next;
  logic             stable;
  logic             leave;

  kp_state_t        state, state_n;
  logic [3:0]       held_key, key_n;
  logic [RW-1:0]    rep_cnt, rep_n;
  logic             push;
  kp_evt_t          push_evt;
  kp_evt_t          head;
  logic [EVT_W-1:0] head_raw;
  logic             empty;
  logic             drop;

  assign tick = (tick_cnt == TICK_LAST);
  assign cur  = {key_down, key_val};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Counter saturates at the stable threshold, so a long hold stays stable
  assign db_next = (cur != sample) ? '0 :
                   (db_cnt == DB_LAST) ? db_cnt : db_cnt + 1'b1;
  assign stable  = (db_next == DB_LAST);
  assign leave   = stable & (~cur[4] | (cur[3:0] != held_key));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample <= '0;
      db_cnt <= '0;
    end else if (tick) begin
      sample <= cur;
      db_cnt <= db_next;
    end
  end

  always_comb begin
    state_n  = state;
    key_n    = held_key;
    rep_n    = rep_cnt;
    push     = 1'b0;
    push_evt = '{typ: EVT_NONE, key: 4'h0};
    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (stable & cur[4]) begin
            push     = 1'b1;
            push_evt = '{typ: EVT_PRESS, key: cur[3:0]};
            key_n    = cur[3:0];
            rep_n    = '0;
            state_n  = S_HELD;
          end
        end
        S_HELD, S_REPEAT: begin
          if (leave) begin
            push     = 1'b1;
            push_evt = '{typ: EVT_RELEASE, key: held_key};
            // held_key already names the incoming key while in SWITCH
            if (cur[4]) key_n = cur[3:0];
            state_n  = cur[4] ? S_SWITCH : S_IDLE;
          end else if (state == S_HELD) begin
            if (rep_cnt != DLY_LAST) begin
              rep_n = rep_cnt + 1'b1;
            end else if (repeat_en) begin
              push     = 1'b1;
              push_evt = '{typ: EVT_REPEAT, key: held_key};
              rep_n    = '0;
              state_n  = S_REPEAT;
            end
          end else if (!repeat_en) begin
            rep_n   = '0;
            state_n = S_HELD;
          end else if (rep_cnt == RATE_LAST) begin
            push     = 1'b1;
            push_evt = '{typ: EVT_REPEAT, key: held_key};
            rep_n    = '0;
          end else begin
            rep_n = rep_cnt + 1'b1;
          end
        end
        S_SWITCH: begin
          push     = 1'b1;
          push_evt = '{typ: EVT_PRESS, key: held_key};
          rep_n    = '0;
          state_n  = S_HELD;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      held_key <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_n;
      held_key <= key_n;
      rep_cnt  <= rep_n;
    end
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (evt_ready),
    .wdata (push_evt),
    .rdata (head_raw),
    .count (fifo_count),
    .empty (empty),
    .drop  (drop)
  );

  assign head      = kp_evt_t'(head_raw);
  assign evt_valid = ~empty;
  assign evt_type  = head.typ;
  assign evt_key   = head.key;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Bench for keypad_event_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a tick-level behavioural model.
module tb_keypad_event_ctrl;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int RD = 3;
  localparam int RR = 2;
  localparam int FD = 4;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] L = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_val = '0;
  logic       key_down = 1'b0;
  logic       repeat_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [3:0] evt_key;
  logic [2:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad = 0;

  keypad_event_ctrl #(
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_val    (key_val),
    .key_down   (key_down),
    .repeat_en  (repeat_en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_type   (evt_type),
    .evt_key    (evt_key),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: tick phase, run length of identical samples,
  // what the held key is doing, and the ticks since its last event.
  int         mcnt = 0;
  logic [4:0] mprev = '0;
  int         mrun = 0;
  int         mmode = 0;
  bit         mrep = 0;
  logic [3:0] mkey = '0;
  int         msince = 0;
  logic [5:0] mq[$];
  bit         movf = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt = 0; mprev = '0; mrun = 0; mmode = 0;
      mrep = 0; mkey = '0; msince = 0; movf = 0;
      mq.delete();
    end else begin
      bit pop, push, stable;
      logic [4:0] s;
      logic [5:0] ev;
      pop = (mq.size() != 0) && evt_ready;
      push = 0;
      ev = '0;
      if (mcnt == TD - 1) begin
        s = {key_down, key_val};
        mrun = (s == mprev) ? mrun + 1 : 0;
        mprev = s;
        stable = (mrun >= DB - 1);
        if (mmode == 2) begin
          push = 1; ev = {P, mkey};
          mmode = 1; mrep = 0; msince = 0;
        end else if (mmode == 0) begin
          if (stable && s[4]) begin
            push = 1; ev = {P, s[3:0]};
            mkey = s[3:0]; mmode = 1; mrep = 0; msince = 0;
          end
        end else if (stable && (!s[4] || s[3:0] != mkey)) begin
          push = 1; ev = {L, mkey};
          if (s[4]) begin mmode = 2; mkey = s[3:0]; end
          else mmode = 0;
        end else begin
          msince++;
          if (mrep) begin
            if (!repeat_en) begin
              mrep = 0; msince = 0;
            end else if (msince >= RR) begin
              push = 1; ev = {R, mkey}; msince = 0;
            end
          end else if (repeat_en && msince >= RD) begin
            push = 1; ev = {R, mkey}; mrep = 1; msince = 0;
          end
        end
      end
      mcnt = (mcnt + 1) % TD;
      if (pop) void'(mq.pop_front());
      if (clr_ovf) movf = 0;
      if (push) begin
        if (mq.size() < FD) mq.push_back(ev);
        else movf = 1;
      end
    end
  end

  // Log of events the DUT handed over, with the cycle of each pop
  int         cyc = 0;
  logic [5:0] dlog[$];
  int         dcyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && evt_valid && evt_ready) begin
      dlog.push_back({evt_type, evt_key});
      dcyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic [10:0] got, exp;
      logic [5:0] h;
      h = (mq.size() != 0) ? mq[0] : 6'h0;
      got = {evt_valid, evt_type, evt_key, fifo_count, overflow};
      exp = {mq.size() != 0, h, 3'(mq.size()), movf};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got v=%b typ=%b key=%h cnt=%0d ovf=%b exp v=%b typ=%b key=%h cnt=%0d ovf=%b",
                 $time, got[10], got[9:8], got[7:4], got[3:1], got[0],
                 exp[10], exp[9:8], exp[7:4], exp[3:1], exp[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_key(input bit d, input logic [3:0] k);
    key_down = d;
    key_val  = k;
  endtask

  task automatic ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  initial begin
    int nrep, badkey, guard;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {evt_valid, evt_type, evt_key, fifo_count, overflow}, 0);
    reset = 1'b0;
    ticks(3);

    // Long hold with repeats, consumer always ready
    evt_ready = 1; repeat_en = 1;
    dlog.delete(); dcyc.delete();
    set_key(1, 4'd5); ticks(20);
    set_key(0, 4'd0); ticks(4);
    nrep = 0; badkey = 0;
    foreach (dlog[i]) begin
      if (dlog[i][5:4] == R) nrep++;
      if (dlog[i][3:0] != 4'd5) badkey++;
    end
    chk("hold_first_press", dlog.size() ? dlog[0] : 6'h0, {P, 4'd5});
    chk("hold_last_release", dlog.size() ? dlog[$] : 6'h0, {L, 4'd5});
    chk("hold_repeats_ge3", 32'(nrep >= 3), 1);
    chk("hold_only_repeats_between", dlog.size(), nrep + 2);
    chk("hold_keys_all_5", badkey, 0);

    // Bouncing key produces nothing
    dlog.delete();
    for (int i = 0; i < 10; i++) begin
      set_key(i % 2 == 0, 4'd7);
      ticks(1);
    end
    set_key(0, 4'd0); ticks(3);
    chk("bounce_no_events", dlog.size(), 0);
    chk("bounce_count_zero", fifo_count, 0);

    // Key switch without release
    repeat_en = 0;
    dlog.delete(); dcyc.delete();
    set_key(1, 4'd3); ticks(4);
    set_key(1, 4'd9); ticks(4);
    set_key(0, 4'd0); ticks(4);
    chk("switch_n", dlog.size(), 4);
    chk("switch_e0", dlog.size() > 0 ? dlog[0] : 6'h0, {P, 4'd3});
    chk("switch_e1", dlog.size() > 1 ? dlog[1] : 6'h0, {L, 4'd3});
    chk("switch_e2", dlog.size() > 2 ? dlog[2] : 6'h0, {P, 4'd9});
    chk("switch_e3", dlog.size() > 3 ? dlog[3] : 6'h0, {L, 4'd9});
    chk("switch_consecutive", dcyc.size() > 2 ? dcyc[2] - dcyc[1] : 0, TD);

    // Overflow with stalled consumer, then clear it
    evt_ready = 0; repeat_en = 1;
    dlog.delete();
    set_key(1, 4'd1); ticks(15);
    chk("ovf_count_full", fifo_count, 4);
    chk("ovf_set", overflow, 1);
    repeat_en = 0; ticks(4);
    clr_ovf = 1; @(negedge clk); clr_ovf = 0;
    chk("ovf_cleared", overflow, 0);

    // Push and pop in the same cycle while full
    guard = 0;
    while (mcnt != TD - 1 && guard < 2 * TD) begin
      @(negedge clk); guard++;
    end
    chk("align_tick", 32'(mcnt == TD - 1), 1);
    repeat_en = 1; evt_ready = 1;
    @(negedge clk);
    evt_ready = 0; repeat_en = 0;
    chk("full_pushpop_count", fifo_count, 4);
    chk("full_pushpop_no_ovf", overflow, 0);
    chk("full_pushpop_popped", dlog.size() ? dlog[$] : 6'h0, {P, 4'd1});

    // Reset while a key is held and events are queued
    evt_ready = 1; set_key(0, 4'd0); ticks(6);
    evt_ready = 0; repeat_en = 1;
    set_key(1, 4'd2); ticks(5);
    chk("pre_reset_count", fifo_count, 2);
    reset = 1; #1;
    chk("reset_mid_valid", evt_valid, 0);
    chk("reset_mid_count", fifo_count, 0);
    set_key(0, 4'd0);
    @(negedge clk); reset = 0;
    ticks(4);
    chk("no_release_after_reset", fifo_count, 0);

    // Random stimulus, checked every cycle by the model
    for (int it = 0; it < 250; it++) begin
      int n;
      set_key($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      repeat_en = ($urandom_range(0, 3) != 0);
      n = $urandom_range(1, 40);
      for (int c = 0; c < n; c++) begin
        evt_ready = ($urandom_range(0, 2) == 0);
        clr_ovf = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      clr_ovf = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
